cmd_receiver: RTL

CMD_RECEIVER -- requirements
Module: cmd_receiver

---
 rtl/cmd_pkg.sv | 23 ++
 rtl/uart_rx.sv | 117 +++++++++++
 rtl/cmd_receiver.sv | 72 +++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: command byte constants, RX FSM state enum and command recognizer; CMD_PARITY_EN adds the PARITY state
package cmd_pkg;
  localparam logic [7:0] CMD_FWD       = 8'h46;
  localparam logic [7:0] CMD_BWD       = 8'h42;
  localparam logic [7:0] CMD_LEFT      = 8'h4C;
  localparam logic [7:0] CMD_RIGHT     = 8'h52;
  localparam logic [7:0] CMD_STOP      = 8'h53;
  localparam logic [7:0] CMD_LIGHT_ON  = 8'h54;
  localparam logic [7:0] CMD_LIGHT_OFF = 8'h74;
  localparam logic [7:0] CMD_SIGN_ON   = 8'h4E;
  localparam logic [7:0] CMD_SIGN_OFF  = 8'h6E;
  localparam logic [7:0] CMD_BUZZ_ON   = 8'h48;
  localparam logic [7:0] CMD_BUZZ_OFF  = 8'h68;
`ifdef CMD_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif
  function automatic logic is_cmd(input logic [7:0] b);
    return b inside {CMD_FWD, CMD_BWD, CMD_LEFT, CMD_RIGHT, CMD_STOP, CMD_LIGHT_ON,
                     CMD_LIGHT_OFF, CMD_SIGN_ON, CMD_SIGN_OFF, CMD_BUZZ_ON, CMD_BUZZ_OFF};
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART deframer with 2-flop synchronizer; CMD_PARITY_EN adds an even-parity bit before the stop bit
module uart_rx
  import cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t r_state, w_state_nxt;
  logic [1:0] r_sync;
  logic r_prev;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic r_valid, w_valid_nxt, r_ferr, w_ferr_nxt;
  logic w_rx, w_fall, w_tick, w_ok;
  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  assign w_tick = r_cnt == FULL;
`ifdef CMD_PARITY_EN
  logic r_perr, w_perr_nxt;
  assign w_ok = w_rx & ~r_perr;
  // latch the even-parity verdict so the stop-bit decision can use it
  always_ff @(posedge clk) begin
    if (!rst_n) r_perr <= 1'b0;
    else r_perr <= w_perr_nxt;
  end
`else
  assign w_ok = w_rx;
`endif
  assign data      = r_shift;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  // resynchronize the line (idle high) and keep the previous level for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_prev <= w_rx;
    end
  end
  // FSM state, bit timing counters, shift register and result strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end
  // next-state: the start bit is sampled at its middle, every later bit one bit period after that
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef CMD_PARITY_EN
    w_perr_nxt  = r_perr;
`endif
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_fall ? RX_START : RX_IDLE;
      end
      RX_START: if (r_cnt == HALF) begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_tick) begin
        w_cnt_nxt   = '0;
        w_shift_nxt = {w_rx, r_shift[7:1]};
        w_bit_nxt   = r_bit + 1'b1;
`ifdef CMD_PARITY_EN
        w_state_nxt = r_bit == 3'd7 ? RX_PARITY : RX_DATA;
`else
        w_state_nxt = r_bit == 3'd7 ? RX_STOP : RX_DATA;
`endif
      end
`ifdef CMD_PARITY_EN
      RX_PARITY: if (w_tick) begin
        w_cnt_nxt   = '0;
        w_perr_nxt  = w_rx != ^r_shift;
        w_state_nxt = RX_STOP;
      end
`endif
      RX_STOP: if (w_tick) begin
        w_cnt_nxt   = '0;
        w_valid_nxt = w_ok;
        w_ferr_nxt  = ~w_ok;
        w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/cmd_receiver.sv
// cmd_receiver: UART command decoder with watchdog failsafe; CMD_PARITY_EN enables even-parity frames
module cmd_receiver
  import cmd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       fwd_in,
  output logic       bwd_in,
  output logic       left_in,
  output logic       right_in,
  output logic       stoplight_in,
  output logic       stopsign_in,
  output logic       failsafe_in,
  output logic       buzzer_in,
  output logic [7:0] last_cmd,
  output logic       frame_err
);
  localparam int CLKS_PER_BIT   = CLK_HZ / BAUD;
  localparam int TIMEOUT_CYCLES = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  logic [7:0] w_data;
  logic w_valid, w_hit, w_to;
  logic w_fwd, w_bwd, w_left, w_right, w_light, w_sign, w_buzz;
  logic [WW-1:0] r_wd;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (w_data),
    .valid     (w_valid),
    .frame_err (frame_err)
  );
  assign w_hit = w_valid & is_cmd(w_data);
  assign w_to  = r_wd == WD_MAX;
  // decode: each command sets its own output and clears the opposing one, others hold
  always_comb begin
    w_fwd   = w_data == CMD_FWD ? 1'b1 : (w_data == CMD_BWD || w_data == CMD_STOP) ? 1'b0 : fwd_in;
    w_bwd   = w_data == CMD_BWD ? 1'b1 : (w_data == CMD_FWD || w_data == CMD_STOP) ? 1'b0 : bwd_in;
    w_left  = w_data == CMD_LEFT ? 1'b1 : (w_data == CMD_RIGHT || w_data == CMD_STOP) ? 1'b0 : left_in;
    w_right = w_data == CMD_RIGHT ? 1'b1 : (w_data == CMD_LEFT || w_data == CMD_STOP) ? 1'b0 : right_in;
    w_light = w_data == CMD_LIGHT_ON ? 1'b1 : w_data == CMD_LIGHT_OFF ? 1'b0 : stoplight_in;
    w_sign  = w_data == CMD_SIGN_ON ? 1'b1 : w_data == CMD_SIGN_OFF ? 1'b0 : stopsign_in;
    w_buzz  = w_data == CMD_BUZZ_ON ? 1'b1 : w_data == CMD_BUZZ_OFF ? 1'b0 : buzzer_in;
  end
  // apply recognized commands (they beat a simultaneous timeout); otherwise run the watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {fwd_in, bwd_in, left_in, right_in, stoplight_in, stopsign_in, buzzer_in} <= '0;
      failsafe_in <= 1'b1;
      last_cmd    <= 8'h00;
      r_wd        <= '0;
    end else if (w_hit) begin
      {fwd_in, bwd_in, left_in, right_in} <= {w_fwd, w_bwd, w_left, w_right};
      {stoplight_in, stopsign_in, buzzer_in} <= {w_light, w_sign, w_buzz};
      failsafe_in <= 1'b0;
      last_cmd    <= w_data;
      r_wd        <= '0;
    end else begin
      r_wd <= w_to ? r_wd : r_wd + 1'b1;
      if (w_to) begin
        {fwd_in, bwd_in, left_in, right_in, buzzer_in} <= '0;
        failsafe_in <= 1'b1;
      end
    end
  end
endmodule
